// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// Takes WIDTH+1 cycles per operation: WIDTH shift steps, then one sign-fixup/write cycle.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   operand_b;  // multiplicand or divisor magnitude
    logic               is_div, neg_main, neg_rem, div_zero;

    logic               is_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quot, rem, hi_fix, lo_fix;

    // Magnitudes are unsigned WIDTH-bit values, so the most-negative operand maps cleanly.
    assign is_signed = ~op[0];
    assign sign_a    = is_signed & opA[WIDTH-1];
    assign sign_b    = is_signed & opB[WIDTH-1];
    assign abs_a     = sign_a ? -opA : opA;
    assign abs_b     = sign_b ? -opB : opB;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: trial-subtract the divisor from the shifted partial remainder.
    assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand_b};
    assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_main ? -acc : acc;
    assign quot     = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    // A zero divisor leaves rem=|opA|, so re-applying opA's sign restores the original opA.
    assign hi_fix   = is_div ? (neg_rem ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_fix   = !is_div  ? prod_fix[WIDTH-1:0] :
                      div_zero ? {WIDTH{1'b1}}       :
                      neg_main ? -quot : quot;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no branch leaves state_next unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            acc       <= '0;
            operand_b <= '0;
            is_div    <= 1'b0;
            neg_main  <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Start has priority: a simultaneous MTHI/MTLO is dropped.
                        acc       <= {{WIDTH{1'b0}}, abs_a};
                        operand_b <= abs_b;
                        count     <= '0;
                        is_div    <= op[1];
                        neg_main  <= sign_a ^ sign_b;
                        neg_rem   <= sign_a;
                        div_zero  <= op[1] && (opB == '0);
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                end
                FIXUP: begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [W-1:0]  opA = '0, opB = '0;
    logic          wr_hi = 1'b0, wr_lo = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic straight from the MIPS definitions.
    task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] h, output logic [W-1:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            2'b10: begin
                if (b == 0) begin h = a; l = '1; end
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            default: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endtask

    // Launch one op and follow it to completion. inject_at>=0 pulses start and
    // MTHI/MTLO in that busy cycle; wr_with_start raises the writes alongside start.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int inject_at, input bit wr_with_start);
        int busy_cycles;
        int done_early;
        bit stable;
        logic [W-1:0] eh, el;
        ref_model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b;
        wr_hi = wr_with_start; wr_lo = wr_with_start; wr_data = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        busy_cycles = 0;
        done_early  = 0;
        stable      = 1'b1;
        while (busy && busy_cycles < 100) begin
            if (done) done_early++;
            if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
            if (busy_cycles == inject_at) begin
                start = 1'b1; op = 2'b11; opA = 32'd9; opB = 32'd2;
                wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h1234_5678;
            end else begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
            busy_cycles++;
            @(negedge clk);
        end
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(W + 1));
        check({tag, " hold"}, 64'(stable), 64'd1);
        check({tag, " no_early_done"}, 64'(done_early), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " done"}, 64'(done), 64'd1);
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        check({tag, " done_1cyc"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic mtx(input string tag, input bit h, input bit l, input logic [W-1:0] d);
        @(negedge clk);
        wr_hi = h; wr_lo = l; wr_data = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
        check({tag, " no_done"}, 64'(done), 64'd0);
    endtask

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    initial begin
        int cyc;
        bit saw_done;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        reset = 1'b0;

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        check("multu_max hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max lo_const", 64'(lo), 64'h0000_0000_0000_0001);
        do_op("mult_neg", 2'b00, -32'sd3, 32'd5, -1, 1'b0);
        check("mult_neg lo_const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
        do_op("div_neg", 2'b10, -32'sd7, 32'd2, -1, 1'b0);
        check("div_neg lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        check("div_neg hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        do_op("divu_zero", 2'b11, 32'd100, 32'd0, -1, 1'b0);
        check("divu_zero hi_const", 64'(hi), 64'h0000_0000_0000_0064);
        do_op("div_zero_neg", 2'b10, -32'sd9, 32'd0, -1, 1'b0);
        do_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        check("div_wrap lo_const", 64'(lo), 64'h0000_0000_8000_0000);
        check("div_wrap hi_const", 64'(hi), 64'd0);
        do_op("mult_minneg", 2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
        do_op("multu_ignore", 2'b01, 32'd6, 32'd7, 10, 1'b0);
        check("multu_ignore lo_const", 64'(lo), 64'd42);

        // MTHI/MTLO in IDLE, alone and together.
        mtx("mthi", 1'b1, 1'b0, 32'hDEAD_BEEF);
        mtx("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D);
        mtx("mthilo", 1'b1, 1'b1, 32'h0BAD_F00D);
        // Start and write in the same cycle: the write must be dropped.
        do_op("start_wr", 2'b11, 32'd1000, 32'd7, -1, 1'b1);

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; opA = 32'd123; opB = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort quiet", 64'(saw_done), 64'd0);
        do_op("after_abort", 2'b01, 32'd2, 32'd3, -1, 1'b0);
        check("after_abort lo_const", 64'(lo), 64'd6);

        // Random ops, operands sometimes drawn from corner values.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            do_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ra, rb, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
